serial_comp: RTL and testbench

Multi-cycle magnitude comparator for the ALU comparison path, the LSB-first counterpart to the MSB-first combinational cascade: it consumes both operands two bits per cycle, starting at bit 0. Later, more significant slices override earlier ones. It accepts one comparison at a time through a start/ready handshake and delivers registered EQ/GT/LT flags with a one-cycle done pulse. Used where the comparison is off the critical path, e.g. multi-cycle branch-condition evaluation, to trade latency for area.

---
 rtl/serial_comp.sv | 138 +++++++++++++
 tb/tb_serial_comp.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/serial_comp.sv
// serial_comp: LSB-first multi-cycle magnitude comparator.
// Both operands are consumed two bits per cycle, starting at bit 0. A later,
// more significant slice that differs overrides any earlier decision. A signed
// compare is reduced to an unsigned one by inverting each operand's MSB when
// the operands are latched.
module serial_comp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             done,
  output logic             EQ,
  output logic             GT,
  output logic             LT
);

  localparam int unsigned NSLICE = WIDTH / 2;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0]    LAST_CNT = CW'(NSLICE - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             eq_r_q, eq_r_d;
  logic             gt_r_q, gt_r_d;
  logic             done_q, done_d;
  logic             eq_o_q, eq_o_d;
  logic             gt_o_q, gt_o_d;
  logic             lt_o_q, lt_o_d;

  logic [CW:0]      slice_idx;
  logic [1:0]       slice_a;
  logic [1:0]       slice_b;

  // Next-state, datapath and output-register logic for the compare sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    eq_r_d  = eq_r_q;
    gt_r_d  = gt_r_q;
    done_d  = 1'b0;
    eq_o_d  = eq_o_q;
    gt_o_d  = gt_o_q;
    lt_o_d  = lt_o_q;

    slice_idx = {cnt_q, 1'b0};
    slice_a   = a_q[slice_idx +: 2];
    slice_b   = b_q[slice_idx +: 2];

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = is_signed ? (A ^ MSB_MASK) : A;
          b_d     = is_signed ? (B ^ MSB_MASK) : B;
          cnt_d   = '0;
          eq_r_d  = 1'b1;
          gt_r_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (slice_a != slice_b) begin
          gt_r_d = (slice_a > slice_b);
          eq_r_d = 1'b0;
        end
        if (cnt_q == LAST_CNT) begin
          // Flags are loaded from the updated running values on the exit edge,
          // so the MSB slice is already folded into the result.
          state_d = DONE;
          done_d  = 1'b1;
          eq_o_d  = eq_r_d;
          gt_o_d  = gt_r_d;
          lt_o_d  = ~eq_r_d & ~gt_r_d;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      eq_r_q  <= 1'b1;
      gt_r_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_o_q  <= 1'b0;
      gt_o_q  <= 1'b0;
      lt_o_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      eq_r_q  <= eq_r_d;
      gt_r_q  <= gt_r_d;
      done_q  <= done_d;
      eq_o_q  <= eq_o_d;
      gt_o_q  <= gt_o_d;
      lt_o_q  <= lt_o_d;
    end
  end

  // Outputs come straight from registers; ready decodes the idle state.
  always_comb begin
    ready = (state_q == IDLE);
    done  = done_q;
    EQ    = eq_o_q;
    GT    = gt_o_q;
    LT    = lt_o_q;
  end

endmodule

// File: tb/tb_serial_comp.sv
// tb_serial_comp: directed self-checking bench for serial_comp (WIDTH=32).
module tb_serial_comp;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        is_signed;
  logic [31:0] A;
  logic [31:0] B;
  logic        ready;
  logic        done;
  logic        EQ;
  logic        GT;
  logic        LT;

  int checks = 0;
  int errors = 0;

  serial_comp #(.WIDTH(32)) dut (
    .clock     (clk),
    .reset_n   (reset_n),
    .start     (start),
    .is_signed (is_signed),
    .A         (A),
    .B         (B),
    .ready     (ready),
    .done      (done),
    .EQ        (EQ),
    .GT        (GT),
    .LT        (LT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Step to the next rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full compare with hand-supplied expected flags {EQ,GT,LT}.
  task automatic compare(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [2:0] exp_flags, input string tag);
    logic [2:0] prev_flags;
    prev_flags = {EQ, GT, LT};
    A = a; B = b; is_signed = s; start = 1'b1;
    step();                        // edge 0: accepted
    start = 1'b0;
    A = ~a; B = ~b; is_signed = ~s; // must not affect the latched operands
    chk(32'(ready), 32'd0, {tag, "_ready_low"});
    repeat (15) step();            // edges 1..15
    chk(32'(done), 32'd0, {tag, "_no_early_done"});
    chk(32'({EQ, GT, LT}), 32'(prev_flags), {tag, "_flags_held_run"});
    step();                        // edge 16
    chk(32'(done), 32'd1, {tag, "_done"});
    chk(32'({EQ, GT, LT}), 32'(exp_flags), {tag, "_flags"});
    step();                        // edge 17
    chk(32'(done), 32'd0, {tag, "_done_pulse"});
    chk(32'(ready), 32'd1, {tag, "_ready_back"});
    chk(32'({EQ, GT, LT}), 32'(exp_flags), {tag, "_flags_hold"});
  endtask

  // Operands presented on each cycle of the continuous-start test.
  task automatic hs_ops(input int idx, output logic [31:0] a, output logic [31:0] b,
                        output logic s);
    case (idx)
      0:       begin a = 32'd10;        b = 32'd20;        s = 1'b0; end
      18:      begin a = 32'd1;         b = 32'hFFFF_FFFF; s = 1'b1; end
      36:      begin a = 32'h1234_5678; b = 32'h1234_5678; s = 1'b0; end
      default: begin a = 32'h5555_0000 | 32'(idx); b = 32'hAAAA_0000; s = idx[0]; end
    endcase
  endtask

  initial begin
    logic [31:0] ha, hb;
    logic        hs;
    logic [2:0]  hflags;

    reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; A = '0; B = '0;
    repeat (2) step();
    chk(32'(ready), 32'd1, "rst_ready");
    chk(32'(done), 32'd0, "rst_done");
    chk(32'({EQ, GT, LT}), 32'd0, "rst_flags");
    reset_n = 1'b1;
    A = 32'h1; B = 32'h2;
    repeat (5) step();
    chk(32'(ready), 32'd1, "idle_ready");
    chk(32'(done), 32'd0, "idle_done");
    chk(32'({EQ, GT, LT}), 32'd0, "idle_flags");

    compare(32'h0000_0005, 32'h0000_0003, 1'b0, 3'b010, "u_gt");
    compare(32'h0000_0003, 32'h0000_0005, 1'b0, 3'b001, "u_lt");
    compare(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b010, "msb_u");
    compare(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b001, "msb_s");
    compare(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3'b100, "eq_u");
    compare(32'h0000_0000, 32'h0000_0000, 1'b1, 3'b100, "eq_s0");

    // start held high: acceptances at edges 0, 18, 36; done after 16, 34, 52.
    hflags = 3'b100;
    hs_ops(0, ha, hb, hs);
    A = ha; B = hb; is_signed = hs; start = 1'b1;
    for (int j = 0; j <= 54; j++) begin
      step();
      chk(32'(done), 32'((j == 16) || (j == 34) || (j == 52)), $sformatf("hs_done_%0d", j));
      chk(32'(ready), 32'((j == 17) || (j == 35) || (j == 53)), $sformatf("hs_ready_%0d", j));
      if (j == 16) hflags = 3'b001;
      if (j == 34) hflags = 3'b010;
      if (j == 52) hflags = 3'b100;
      chk(32'({EQ, GT, LT}), 32'(hflags), $sformatf("hs_flags_%0d", j));
      hs_ops(j + 1, ha, hb, hs);
      A = ha; B = hb; is_signed = hs;
    end
    start = 1'b0;
    repeat (2) step();

    // Reset asserted for the edge 8 cycles into a compare.
    A = 32'h0000_00F0; B = 32'h0000_000F; is_signed = 1'b0; start = 1'b1;
    step();                         // edge 0
    start = 1'b0;
    repeat (7) step();              // edges 1..7
    reset_n = 1'b0;
    step();                         // edge 8 under reset
    chk(32'(ready), 32'd1, "mid_rst_ready");
    chk(32'(done), 32'd0, "mid_rst_done");
    chk(32'({EQ, GT, LT}), 32'd0, "mid_rst_flags");
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk(32'(done), 32'd0, $sformatf("mid_rst_nodone_%0d", k));
    end
    compare(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 3'b001, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
